// File: rtl/blockchain_auditor_pkg.sv
// Shared block layout and auditor state encoding for the blockchain storage slice.
package blockchain_auditor_pkg;

    localparam int unsigned BLK_W      = 64;
    localparam int unsigned BLK_DATA_W = 48;
    localparam int unsigned HASH_W     = 8;

    // One stored block: link field, own hash, balance snapshot
    typedef struct packed {
        logic [HASH_W-1:0]     prev_hash;
        logic [HASH_W-1:0]     hash;
        logic [BLK_DATA_W-1:0] balance;
    } block_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } audit_state_e;

endpackage

// File: rtl/blockchain_auditor.sv
// blockchain_auditor: walks stored blocks 0..N-1 over the shared RAM read port,
// streams each block out and checks prev-hash linkage (plus optional difficulty).
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   start, num_blocks       audit request (sampled in IDLE) and chain length
//   ram_busy                writer owns the RAM; address issue stalls
//   rd_addr, rd_en, rd_data RAM read port (rd_en follows ram_busy within the cycle)
//   blk_valid/data/index    per-block stream
//   busy, done              audit in progress / one-cycle completion pulse
//   chain_ok, bad_index     result and first failing block
//   audited                 number of blocks checked
module blockchain_auditor
    import blockchain_auditor_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 5,
    parameter int unsigned       RD_LATENCY   = 1,
    parameter logic [HASH_W-1:0] GENESIS_PREV = 8'h00,
    parameter int unsigned       DIFF_BITS    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_blocks,
    input  logic              ram_busy,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [BLK_W-1:0]  rd_data,
    output logic              blk_valid,
    output logic [BLK_W-1:0]  blk_data,
    output logic [ADDR_W-1:0] blk_index,
    output logic              busy,
    output logic              done,
    output logic              chain_ok,
    output logic [ADDR_W-1:0] bad_index,
    output logic [ADDR_W:0]   audited
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  MAX_N     = CNT_W'(2 ** ADDR_W);
    localparam logic [HASH_W-1:0] DIFF_MASK = HASH_W'((1 << DIFF_BITS) - 1);
    localparam int unsigned       WAIT_W    = 4;
    localparam int unsigned       WAIT_INIT = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    audit_state_e      state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [HASH_W-1:0] last_hash_q, last_hash_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              blk_valid_q, blk_valid_d;
    logic [BLK_W-1:0]  blk_data_q, blk_data_d;
    logic [ADDR_W-1:0] blk_index_q, blk_index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              chain_ok_q, chain_ok_d;
    logic [ADDR_W-1:0] bad_index_q, bad_index_d;
    logic [CNT_W-1:0]  audited_q, audited_d;

    block_t            blk;
    logic [CNT_W-1:0]  n_clamped;
    logic              link_ok;
    logic              last_blk;

    assign blk       = rd_data;
    assign n_clamped = (num_blocks > MAX_N) ? MAX_N : num_blocks;
    assign link_ok   = (blk.prev_hash == last_hash_q) && ((blk.hash & DIFF_MASK) == '0);
    assign last_blk  = (idx_q == (n_q - CNT_W'(1)));

    // Address comes straight from the block counter; the strobe must drop in
    // the same cycle the writer claims the RAM, so it is gated by ram_busy.
    assign rd_addr = idx_q[ADDR_W-1:0];
    assign rd_en   = (state_q == ST_ISSUE) && !ram_busy;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        last_hash_d = last_hash_q;
        wait_d      = wait_q;
        blk_valid_d = 1'b0;
        blk_data_d  = blk_data_q;
        blk_index_d = blk_index_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        chain_ok_d  = chain_ok_q;
        bad_index_d = bad_index_q;
        audited_d   = audited_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d         = n_clamped;
                    idx_d       = '0;
                    last_hash_d = GENESIS_PREV;
                    chain_ok_d  = 1'b0;
                    bad_index_d = '0;
                    audited_d   = '0;
                    if (n_clamped == '0) begin
                        // Empty chain is trivially valid
                        chain_ok_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = ST_FIN;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (!ram_busy) begin
                    if (RD_LATENCY > 1) begin
                        wait_d  = WAIT_W'(WAIT_INIT);
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end

            // Covers the extra RAM latency beyond the first cycle
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            ST_CHECK: begin
                blk_valid_d = 1'b1;
                blk_data_d  = blk;
                blk_index_d = idx_q[ADDR_W-1:0];
                audited_d   = audited_q + CNT_W'(1);
                if (!link_ok) begin
                    bad_index_d = idx_q[ADDR_W-1:0];
                    chain_ok_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_FIN;
                end else begin
                    last_hash_d = blk.hash;
                    if (last_blk) begin
                        chain_ok_d = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_FIN;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end

            // done is visible this cycle; start is deliberately not sampled here
            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            last_hash_q <= GENESIS_PREV;
            wait_q      <= '0;
            blk_valid_q <= 1'b0;
            blk_data_q  <= '0;
            blk_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            chain_ok_q  <= 1'b0;
            bad_index_q <= '0;
            audited_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            last_hash_q <= last_hash_d;
            wait_q      <= wait_d;
            blk_valid_q <= blk_valid_d;
            blk_data_q  <= blk_data_d;
            blk_index_q <= blk_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            chain_ok_q  <= chain_ok_d;
            bad_index_q <= bad_index_d;
            audited_q   <= audited_d;
        end
    end

    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_data_q;
    assign blk_index = blk_index_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign chain_ok  = chain_ok_q;
    assign bad_index = bad_index_q;
    assign audited   = audited_q;

endmodule
